ahb_ram_slave: RTL and testbench
================================

Name: ahb_ram_slave

Overview:
- AHB-Lite responder: single-port 32-bit word RAM behind the interconnect's HSEL2 / data-slave path.
- Captures the address phase, inserts a programmable number of wait states, then completes the data phase.
- Sources hrdata_data, hready_data and hresp_data back to the interconnect mux.
- Does byte/halfword lane steering and signed/unsigned read extension.

Parameters:
- ADDR_WIDTH, 10, word-address bits. Depth is 2**ADDR_WIDTH words, decoded from haddr[ADDR_WIDTH+1:2]; upper bits are ignored.
- WAIT_STATES, 1, hready_out=0 cycles inserted before each OKAY completion. Legal range 0..15.

Ports:
- clk  input  1  system clock; all flops on rising edge.
- reset  input  1  asynchronous, active-low reset.
- hsel  input  1  slave select from decoder (HSEL2).
- haddr  input  32  byte address.
- htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite  input  1  1 = write.
- hsize  input  3  0 byte, 1 halfword, 2 word; others illegal.
- hprot  input  4  accepted, ignored.
- hwdata  input  32  write data, right-justified, valid in data phase.
- is_signed  input  1  read extension select, sampled in address phase.
- hready  input  1  bus-wide HREADY from interconnect mux.
- hrdata  output  32  read data.
- hready_out  output  1  slave ready (to hready_data).
- hresp  output  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset (reset=0, async): state IDLE, wait counter 0, captured address-phase registers 0, hready_out=1, hresp=0, hrdata=0. RAM contents are not reset.
- Address phase accepted on a rising edge with hsel && htrans[1] && hready. Captured: haddr, hwrite, hsize, is_signed.
- Cycles with hsel=0 or htrans=IDLE/BUSY: no access, hready_out=1, hresp=0.
- Legality check at acceptance:
  - Illegal if hsize>2.
  - Illegal if hsize=1 with haddr[0]=1.
  - Illegal if hsize=2 with haddr[1:0]!=0.
- States:
  - IDLE: hready_out=1, hresp=0. A legal accept goes to WAIT if WAIT_STATES>0, else RESP. An illegal accept goes to ERR1.
  - WAIT: hready_out=0, hresp=0. Counter loads WAIT_STATES-1 on entry and decrements each cycle; go to RESP when it reaches 0.
  - RESP: hready_out=1, hresp=0; final data-phase cycle. A new legal or illegal accept in this same cycle (pipelined) re-enters WAIT/RESP/ERR1 accordingly; otherwise go to IDLE.
  - ERR1: hready_out=0, hresp=1, no RAM access. Go to ERR2.
  - ERR2: hready_out=1, hresp=1. Transfer accepted here is handled as from IDLE.
- Latency: accept at edge N → WAIT_STATES stall cycles → RESP cycle. Total data phase is WAIT_STATES+1 cycles.
- Write commit: at the rising edge ending RESP. Byte lanes are selected by captured haddr[1:0] (little-endian):
  - byte: hwdata[7:0] goes to lane haddr[1:0].
  - halfword: hwdata[15:0] goes to lanes {haddr[1],0}+1..0.
  - word: all 32 bits.
  - Unselected lanes are unchanged.
- Read: in RESP, hrdata is the RAM word at the captured address, lane-extracted and right-justified.
  - is_signed=1: sign-extend from bit 7 (byte) or bit 15 (halfword).
  - is_signed=0: zero-extend.
  - Word reads pass through unchanged.
  - hrdata=0 in all other states.
- Read-after-write: a read whose address phase overlaps a write's RESP cycle returns the newly written data (commit precedes the read sample).
- hwdata is ignored outside write RESP; hprot has no effect.
- Reset asserted mid-transfer: immediately forces IDLE outputs; any pending write is dropped.

Test Plan:
- Reset, then idle bus with hsel=0 → hready_out=1, hresp=0, hrdata=0 continuously.
- WAIT_STATES=1:
  - Word write 0xDEADBEEF to 0x10, then word read 0x10 → each data phase is one cycle hready_out=0, then one cycle hready_out=1.
  - The read's RESP cycle shows hrdata=0xDEADBEEF.
- Byte write 0x80 to 0x13, then reads of 0x13:
  - byte read, is_signed=1 → hrdata=0xFFFFFF80.
  - byte read, is_signed=0 → 0x00000080.
  - word read of 0x10 → 0x80ADBEEF.
- Halfword access to 0x21 or word access to 0x22 → ERR1 (hready_out=0, hresp=1), then ERR2 (hready_out=1, hresp=1); a subsequent read shows RAM unchanged.
- WAIT_STATES=0:
  - Back-to-back NONSEQ write 0x12345678 to 0x40, then read 0x40 → both complete with hready_out=1 every cycle.
  - The read returns 0x12345678.
- Assert reset during a WAIT cycle of a write → hready_out=1 and hresp=0 immediately; a later read of that address returns the old value.

Source files
------------

// File: rtl/ahb_ram_slave.sv
// AHB-Lite word RAM responder with programmable wait states, lane steering and
// signed/unsigned read extension.
// Ports:
//   clk, reset (async, active-low)
//   hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, is_signed, hready : AHB-Lite inputs
//   hrdata, hready_out, hresp : registered data-phase responses
module ahb_ram_slave #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        is_signed,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hready_out,
  output logic        hresp
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned AW    = ADDR_WIDTH + 2;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RESP, S_ERR1, S_ERR2} state_e;

  logic [31:0]     mem [DEPTH];

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic [1:0]      size_q, size_d;
  logic            sgn_q, sgn_d;
  logic [31:0]     hrdata_q, hrdata_d;
  logic            hready_q, hready_d;
  logic            hresp_q, hresp_d;

  logic            accept_c, legal_c, commit_c;
  logic [3:0]      be_c;
  logic [31:0]     wlanes_c, merged_c, rd_word_c, rd_sh_c;
  logic [ADDR_WIDTH-1:0] wr_idx_c, rd_idx_c;

  // Address-phase bits and attributes the design has no use for.
  logic unused_ok;
  assign unused_ok = ^{hprot, htrans[0], haddr[31:AW]};

  // New transfers are only taken where an address phase can overlap a free data phase.
  assign accept_c = hsel && htrans[1] && hready &&
                    (state_q == S_IDLE || state_q == S_RESP || state_q == S_ERR2);

  always_comb begin
    legal_c = 1'b0;
    case (hsize)
      3'd0:    legal_c = 1'b1;
      3'd1:    legal_c = !haddr[0];
      3'd2:    legal_c = (haddr[1:0] == 2'b00);
      default: legal_c = 1'b0;
    endcase
  end

  // Address-phase capture.
  always_comb begin
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    if (accept_c) begin
      addr_d  = haddr[AW-1:0];
      write_d = hwrite;
      size_d  = hsize[1:0];
      sgn_d   = is_signed;
    end
  end

  // Next-state and wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_RESP, S_ERR2: begin
        state_d = S_IDLE;
        if (accept_c) begin
          if (!legal_c) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  // Write lane steering; commit happens on the edge that ends the RESP cycle.
  assign commit_c = (state_q == S_RESP) && write_q;
  assign wr_idx_c = addr_q[AW-1:2];

  always_comb begin
    be_c     = 4'b1111;
    wlanes_c = hwdata;
    case (size_q)
      2'd0: begin
        be_c     = 4'(4'b0001 << addr_q[1:0]);
        wlanes_c = {4{hwdata[7:0]}};
      end
      2'd1: begin
        be_c     = addr_q[1] ? 4'b1100 : 4'b0011;
        wlanes_c = {2{hwdata[15:0]}};
      end
      default: ;
    endcase
    merged_c = mem[wr_idx_c];
    for (int i = 0; i < 4; i++) begin
      if (be_c[i]) merged_c[8*i +: 8] = wlanes_c[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (commit_c) mem[wr_idx_c] <= merged_c;
  end

  // Read word for the upcoming RESP cycle, forwarding a write committing on the same edge.
  assign rd_idx_c  = addr_d[AW-1:2];
  assign rd_word_c = (commit_c && (rd_idx_c == wr_idx_c)) ? merged_c : mem[rd_idx_c];
  assign rd_sh_c   = rd_word_c >> {addr_d[1:0], 3'b000};

  // Output decode from the next state so every output is a flop.
  always_comb begin
    hready_d = !(state_d == S_WAIT || state_d == S_ERR1);
    hresp_d  = (state_d == S_ERR1 || state_d == S_ERR2);
    hrdata_d = 32'd0;
    if (state_d == S_RESP && !write_d) begin
      case (size_d)
        2'd0:    hrdata_d = {{24{sgn_d & rd_sh_c[7]}},  rd_sh_c[7:0]};
        2'd1:    hrdata_d = {{16{sgn_d & rd_sh_c[15]}}, rd_sh_c[15:0]};
        default: hrdata_d = rd_word_c;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= 2'd0;
      sgn_q    <= 1'b0;
      hrdata_q <= 32'd0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
      sgn_q    <= sgn_d;
      hrdata_q <= hrdata_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  assign hrdata     = hrdata_q;
  assign hready_out = hready_q;
  assign hresp      = hresp_q;

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Directed bench: one instance with WAIT_STATES=0 (dut 0), one with WAIT_STATES=1 (dut 1).
module tb_ahb_ram_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hsel0, hsel1;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite, is_signed;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hrdata0, hrdata1;
  logic        hready0, hready1, hresp0, hresp1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ahb_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
    .is_signed(is_signed), .hready(hready0),
    .hrdata(hrdata0), .hready_out(hready0), .hresp(hresp0));

  ahb_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .reset(reset), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
    .is_signed(is_signed), .hready(hready1),
    .hrdata(hrdata1), .hready_out(hready1), .hresp(hresp1));

  typedef struct {
    int          dut;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sgn;
    logic [31:0] exp;
    logic        err;
    int          waits;
  } vec_t;

  vec_t vecs[21];

  function automatic logic rdy(int d);  return (d == 0) ? hready0 : hready1; endfunction
  function automatic logic rsp(int d);  return (d == 0) ? hresp0  : hresp1;  endfunction
  function automatic logic [31:0] rdat(int d); return (d == 0) ? hrdata0 : hrdata1; endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic addr_phase(int d, logic wr, logic [2:0] sz, logic [31:0] a, logic sgn);
    hsel0     = (d == 0);
    hsel1     = (d == 1);
    htrans    = 2'b10;
    hwrite    = wr;
    hsize     = sz;
    haddr     = a;
    is_signed = sgn;
    hprot     = 4'($urandom_range(0, 15));
  endtask

  task automatic idle_bus();
    hsel0  = 1'b0;
    hsel1  = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  task automatic idle_checks(string tag);
    chk({tag, " idle hready0"}, 32'(hready0), 32'd1);
    chk({tag, " idle hready1"}, 32'(hready1), 32'd1);
    chk({tag, " idle hresp1"},  32'(hresp1),  32'd0);
    chk({tag, " idle hrdata1"}, hrdata1,      32'd0);
  endtask

  // Single non-pipelined transfer: address phase, stalls counted, final cycle checked.
  task automatic xfer(vec_t v, string tag);
    int w;
    @(negedge clk);
    addr_phase(v.dut, v.wr, v.size, v.addr, v.sgn);
    @(negedge clk);
    idle_bus();
    hwdata = v.wdata;
    w = 0;
    while (!rdy(v.dut) && w < 20) begin
      chk({tag, " stall hresp"}, 32'(rsp(v.dut)), 32'(v.err));
      w++;
      @(negedge clk);
    end
    chk({tag, " waits"}, 32'(w), 32'(v.waits));
    chk({tag, " hresp"}, 32'(rsp(v.dut)), 32'(v.err));
    if (!v.wr && !v.err) chk({tag, " hrdata"}, rdat(v.dut), v.exp);
    @(negedge clk);
    hwdata = 32'd0;
    chk({tag, " after hready"}, 32'(rdy(v.dut)), 32'd1);
    chk({tag, " after hresp"},  32'(rsp(v.dut)), 32'd0);
    chk({tag, " after hrdata"}, rdat(v.dut),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t rv;
    //            dut wr sz    addr          wdata         sg exp           er wt
    vecs[0]  = '{1, 1, 3'd2, 32'h0000_0010, 32'hDEADBEEF, 0, 32'h0,        0, 1};
    vecs[1]  = '{1, 0, 3'd2, 32'h0000_0010, 32'h0,        0, 32'hDEADBEEF, 0, 1};
    vecs[2]  = '{1, 1, 3'd0, 32'h0000_0013, 32'hAAAAAA80, 0, 32'h0,        0, 1};
    vecs[3]  = '{1, 0, 3'd0, 32'h0000_0013, 32'h0,        1, 32'hFFFFFF80, 0, 1};
    vecs[4]  = '{1, 0, 3'd0, 32'h0000_0013, 32'h0,        0, 32'h00000080, 0, 1};
    vecs[5]  = '{1, 0, 3'd2, 32'h0000_0010, 32'h0,        0, 32'h80ADBEEF, 0, 1};
    vecs[6]  = '{1, 0, 3'd1, 32'h0000_0012, 32'h0,        1, 32'hFFFF80AD, 0, 1};
    vecs[7]  = '{1, 0, 3'd1, 32'h0000_0010, 32'h0,        0, 32'h0000BEEF, 0, 1};
    vecs[8]  = '{1, 1, 3'd2, 32'h0000_0020, 32'hCAFEF00D, 0, 32'h0,        0, 1};
    vecs[9]  = '{1, 1, 3'd1, 32'h0000_0021, 32'h00001234, 0, 32'h0,        1, 1};
    vecs[10] = '{1, 1, 3'd2, 32'h0000_0022, 32'h11111111, 0, 32'h0,        1, 1};
    vecs[11] = '{1, 0, 3'd3, 32'h0000_0020, 32'h0,        0, 32'h0,        1, 1};
    vecs[12] = '{1, 0, 3'd2, 32'h0000_0020, 32'h0,        0, 32'hCAFEF00D, 0, 1};
    vecs[13] = '{1, 1, 3'd2, 32'h0000_0024, 32'h11223344, 0, 32'h0,        0, 1};
    vecs[14] = '{1, 1, 3'd1, 32'h0000_0026, 32'hFFFFA55A, 0, 32'h0,        0, 1};
    vecs[15] = '{1, 0, 3'd2, 32'h0000_0024, 32'h0,        0, 32'hA55A3344, 0, 1};
    vecs[16] = '{1, 0, 3'd0, 32'h0000_0025, 32'h0,        1, 32'h00000033, 0, 1};
    vecs[17] = '{1, 0, 3'd2, 32'h0000_1010, 32'h0,        0, 32'h80ADBEEF, 0, 1};
    vecs[18] = '{0, 1, 3'd2, 32'h0000_0040, 32'h12345678, 0, 32'h0,        0, 0};
    vecs[19] = '{0, 0, 3'd2, 32'h0000_0040, 32'h0,        0, 32'h12345678, 0, 0};
    vecs[20] = '{1, 0, 3'd0, 32'h0000_0011, 32'h0,        1, 32'hFFFFFFBE, 0, 1};

    idle_bus();
    haddr = 32'd0; hsize = 3'd0; hprot = 4'd0; hwdata = 32'd0; is_signed = 1'b0;

    // Reset values, then an idle bus.
    @(negedge clk);
    idle_checks("reset");
    chk("reset hresp0", 32'(hresp0), 32'd0);
    chk("reset hrdata0", hrdata0, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_checks($sformatf("idle%0d", i));
    end

    for (int i = 0; i < 21; i++) xfer(vecs[i], $sformatf("v%0d", i));

    // WAIT_STATES=0 back-to-back write then read of the same word.
    @(negedge clk);
    addr_phase(0, 1'b1, 3'd2, 32'h44, 1'b0);
    @(negedge clk);
    chk("b2b wr hready", 32'(hready0), 32'd1);
    chk("b2b wr hresp", 32'(hresp0), 32'd0);
    hwdata = 32'h0BADF00D;
    addr_phase(0, 1'b0, 3'd2, 32'h44, 1'b0);
    @(negedge clk);
    chk("b2b rd hready", 32'(hready0), 32'd1);
    chk("b2b rd hrdata", hrdata0, 32'h0BADF00D);
    idle_bus();
    hwdata = 32'd0;
    @(negedge clk);
    chk("b2b idle hrdata", hrdata0, 32'd0);

    // WAIT_STATES=1 read address phase held through the write's stall.
    @(negedge clk);
    addr_phase(1, 1'b1, 3'd2, 32'h50, 1'b0);
    @(negedge clk);
    chk("pipe wr wait", 32'(hready1), 32'd0);
    hwdata = 32'h5A5A0F0F;
    addr_phase(1, 1'b0, 3'd2, 32'h50, 1'b0);
    @(negedge clk);
    chk("pipe wr resp", 32'(hready1), 32'd1);
    chk("pipe wr hrdata", hrdata1, 32'd0);
    @(negedge clk);
    chk("pipe rd wait", 32'(hready1), 32'd0);
    idle_bus();
    hwdata = 32'd0;
    @(negedge clk);
    chk("pipe rd resp", 32'(hready1), 32'd1);
    chk("pipe rd hrdata", hrdata1, 32'h5A5A0F0F);
    @(negedge clk);

    // Reset during a write's wait cycle drops the write.
    @(negedge clk);
    addr_phase(1, 1'b1, 3'd2, 32'h10, 1'b0);
    @(negedge clk);
    idle_bus();
    hwdata = 32'h55555555;
    chk("rst wr wait", 32'(hready1), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("rst hready", 32'(hready1), 32'd1);
    chk("rst hresp", 32'(hresp1), 32'd0);
    chk("rst hrdata", hrdata1, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    hwdata = 32'd0;
    rv = '{1, 0, 3'd2, 32'h10, 32'h0, 0, 32'h80ADBEEF, 0, 1};
    xfer(rv, "rst rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
